// File: rtl/menu_arrow_if.sv
// Signal bundle between the menu screen logic and the arrow controller.
// The master drives the ticks and buttons; the slave returns the arrow sprite origin and selection.
interface menu_arrow_if #(
    parameter int IDX_W = 2
);
    logic             frame_tick;
    logic             enable;
    logic             btn_up;
    logic             btn_down;
    logic             btn_sel;
    logic [9:0]       arrow_x;
    logic [9:0]       arrow_y;
    logic             arrow_vis;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;

    modport master (
        output frame_tick, enable, btn_up, btn_down, btn_sel,
        input  arrow_x, arrow_y, arrow_vis, sel_idx, sel_valid
    );

    modport slave (
        input  frame_tick, enable, btn_up, btn_down, btn_sel,
        output arrow_x, arrow_y, arrow_vis, sel_idx, sel_valid
    );
endinterface

// File: rtl/menu_arrow_ctrl.sv
// Menu selection arrow: moves, blinks and confirms on frame_tick only, so the sprite never tears.
// state | meaning: IDLE hidden, waiting | BROWSE slow blink, moving | CONFIRM fast blink | DONE shown, frozen
module menu_arrow_ctrl #(
    parameter int N_ITEMS        = 3,
    parameter int IDX_W          = 2,
    parameter int BASE_X         = 312,
    parameter int BASE_Y         = 194,
    parameter int ITEM_PITCH     = 24,
    parameter int BLINK_FRAMES   = 30,
    parameter int CONFIRM_FRAMES = 48
) (
    input  logic        clk,
    input  logic        reset,
    menu_arrow_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BROWSE, CONFIRM, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             vis, vis_nxt, valid, valid_nxt;
    logic [5:0]       blink_cnt, blink_nxt, conf_cnt, conf_nxt;
    logic [9:0]       pos_x, pos_y;
    // bit 0 up, bit 1 down, bit 2 select
    logic [2:0]       btn, hist, pend, pend_nxt, req;

    assign btn = {bus.btn_sel, bus.btn_down, bus.btn_up};
    assign req = pend | (btn & ~hist);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            vis       <= 1'b0;
            valid     <= 1'b0;
            blink_cnt <= '0;
            conf_cnt  <= '0;
            hist      <= '0;
            pend      <= '0;
            pos_x     <= 10'(BASE_X);
            pos_y     <= 10'(BASE_Y);
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            vis       <= vis_nxt;
            valid     <= valid_nxt;
            blink_cnt <= blink_nxt;
            conf_cnt  <= conf_nxt;
            hist      <= btn;
            pend      <= pend_nxt;
            pos_x     <= 10'(BASE_X);
            pos_y     <= 10'(BASE_Y) + 10'(idx_nxt) * 10'(ITEM_PITCH);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        vis_nxt   = vis;
        valid_nxt = 1'b0;
        blink_nxt = blink_cnt;
        conf_nxt  = conf_cnt;
        pend_nxt  = '0;
        if (!bus.enable) begin
            // sel_idx deliberately held so the consumer can still read the last choice
            state_nxt = IDLE;
            vis_nxt   = 1'b0;
            blink_nxt = '0;
            conf_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    vis_nxt = 1'b0;
                    if (bus.frame_tick) begin
                        state_nxt = BROWSE;
                        idx_nxt   = '0;
                        vis_nxt   = 1'b1;
                        blink_nxt = '0;
                    end
                end
                BROWSE: begin
                    pend_nxt = req;
                    if (bus.frame_tick) begin
                        pend_nxt = '0;
                        if (req[2]) begin
                            state_nxt = CONFIRM;
                            conf_nxt  = '0;
                            blink_nxt = '0;
                            vis_nxt   = 1'b1;
                        end else if (req[0] ^ req[1]) begin
                            if (req[0])
                                idx_nxt = (idx == '0) ? IDX_W'(N_ITEMS - 1) : idx - IDX_W'(1);
                            else
                                idx_nxt = (idx == IDX_W'(N_ITEMS - 1)) ? '0 : idx + IDX_W'(1);
                            vis_nxt   = 1'b1;
                            blink_nxt = '0;
                        end else if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
                            blink_nxt = '0;
                            vis_nxt   = ~vis;
                        end else begin
                            blink_nxt = blink_cnt + 6'd1;
                        end
                    end
                end
                CONFIRM: begin
                    if (bus.frame_tick) begin
                        if (conf_cnt == 6'(CONFIRM_FRAMES - 1)) begin
                            state_nxt = DONE;
                            valid_nxt = 1'b1;
                            vis_nxt   = 1'b1;
                            conf_nxt  = '0;
                        end else begin
                            if (conf_cnt[1:0] == 2'd3)
                                vis_nxt = ~vis;
                            conf_nxt = conf_cnt + 6'd1;
                        end
                    end
                end
                DONE: vis_nxt = 1'b1;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign bus.arrow_x   = pos_x;
    assign bus.arrow_y   = pos_y;
    assign bus.arrow_vis = vis;
    assign bus.sel_idx   = idx;
    assign bus.sel_valid = valid;
endmodule
